// File: rtl/mdu_hilo_pkg.sv
// Shared constants for the multiply/divide unit: op encoding, read selects
// and default latencies, used by the MDU, the decoder and the hazard unit.
package mdu_hilo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  localparam logic MD_SEL_LO = 1'b0;
  localparam logic MD_SEL_HI = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // True for the multi-cycle ops that occupy the unit.
  function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit with HI/LO registers; results computed at
// accept time and committed after a fixed busy latency.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic               md_sel,
  output logic [DATA_W-1:0]  md_out,
  output logic               busy,
  output logic               stall_req
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  hilo_t             arch;
  hilo_t             temp;
  logic [CNT_W-1:0]  cnt;
  logic              no_commit;

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   quot_s;
  logic [DATA_W-1:0]   rem_s;
  logic [DATA_W-1:0]   quot_u;
  logic [DATA_W-1:0]   rem_u;

  // Full-width products: operands extended to 64 bits so no result bits are lost.
  always_comb begin
    prod_s = 64'($signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) *
                 $signed({{DATA_W{src_b[DATA_W-1]}}, src_b}));
    prod_u = 64'({{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b});
  end

  // Quotient/remainder; divide-by-zero and the single signed overflow case are
  // resolved explicitly instead of relying on the arithmetic operators.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (src_b != '0) begin
      quot_u = src_a / src_b;
      rem_u  = src_a % src_b;
      if ((src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF)) begin
        quot_s = 32'h8000_0000;
        rem_s  = '0;
      end else begin
        quot_s = 32'($signed(src_a) / $signed(src_b));
        rem_s  = 32'($signed(src_a) % $signed(src_b));
      end
    end
  end

  // Counter, pending result and HI/LO; a start while busy falls through unseen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      arch      <= '0;
      temp      <= '0;
      cnt       <= '0;
      no_commit <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && !no_commit) begin
        arch <= temp;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT: begin
          temp      <= hilo_t'(prod_s);
          cnt       <= MULT_LD;
          no_commit <= 1'b0;
        end
        MD_MULTU: begin
          temp      <= hilo_t'(prod_u);
          cnt       <= MULT_LD;
          no_commit <= 1'b0;
        end
        MD_DIV: begin
          temp      <= '{hi: rem_s, lo: quot_s};
          cnt       <= DIV_LD;
          no_commit <= (src_b == '0);
        end
        MD_DIVU: begin
          temp      <= '{hi: rem_u, lo: quot_u};
          cnt       <= DIV_LD;
          no_commit <= (src_b == '0);
        end
        MD_MTHI: arch.hi <= src_a;
        MD_MTLO: arch.lo <= src_a;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (cnt != '0);
    stall_req = busy | (start & is_muldiv(md_op));
    md_out    = (md_sel == MD_SEL_HI) ? arch.hi : arch.lo;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers, in the E stage.
- Consumes the two operands read from the register file (after forwarding) and produces mfhi/mflo data.
- That data travels down the pipeline to the register-file write port.
- Models multi-cycle mult/div latency with a busy counter; the hazard unit uses `busy` and `start` to stall the D stage.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after accepting mult/multu (must be >= 1)
- DIV_CYCLES, 10, cycles busy is held after accepting div/divu (must be >= 1)

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state
- start  input  1  E-stage instruction is a valid MDU op this cycle
- md_op  input  3  operation code (package constants)
- src_a  input  32  rs operand
- src_b  input  32  rt operand
- md_sel  input  1  read select for md_out: 0=LO, 1=HI
- md_out  output  32  combinational read of HI or LO per md_sel
- busy  output  1  mult/div in progress
- stall_req  output  1  busy | (start & op is mult/multu/div/divu)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-low, and named reset.
- Reset state: at a clk edge with reset==0:
  - HI=0, LO=0, counter=0, busy=0, temp result registers=0.
  - A mult/div in flight is aborted and leaves no update.
  - Reset has priority over all other inputs.
- md_op encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is reserved and treated as NOP.
- Accept rule: start is honoured only when busy==0; start while busy==1 is ignored with no state change. The hazard unit guarantees this does not occur; the verifier checks that it is ignored.
- MULT/MULTU, on the accept edge:
  - temp = src_a*src_b as a 64-bit product, signed or unsigned per op.
  - counter <= MULT_CYCLES.
- DIV/DIVU, on the accept edge:
  - temp_lo = quotient, temp_hi = remainder, signed or unsigned per op.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): temp_lo = 0x80000000, temp_hi = 0.
  - src_b==0: a do-not-commit flag is set. The counter still runs DIV_CYCLES, and HI/LO are left unchanged at completion.
  - counter <= DIV_CYCLES.
- busy = (counter != 0).
  - Each edge with counter != 0 decrements it.
  - On the edge where counter goes 1->0: HI <= temp_hi, LO <= temp_lo, unless the do-not-commit flag is set.
- Latency: with accept at edge N, busy is high for cycles N..N+C-1 (C = cycle parameter). The new HI/LO is visible on md_out from the cycle after edge N+C. busy is 0 in that same cycle.
- MTHI/MTLO: when accepted, HI (or LO) <= src_a at the accept edge. Busy is not affected and the value is readable the next cycle.
- md_out during busy returns the old HI/LO. The hazard unit stalls mfhi/mflo while stall_req is set, so this value is never consumed.
- stall_req is combinational. It goes high in the same cycle as an accepted mult/div start, so the following instruction is held.
- Back-to-back: a new start may be accepted in the first cycle where busy==0, i.e. the cycle HI/LO become visible.

Decomposition:
- Shared package holds:
  - md_op constants (MD_NOP .. MD_MTLO) and their width.
  - MD_SEL_LO/MD_SEL_HI.
  - Default MULT_CYCLES/DIV_CYCLES.
  - Decoder and hazard unit import the same constants.
- No sub-module: the arithmetic is behavioural `*`, `/`, `%` computed at accept time, and the counter and commit logic are small. Total 120-200 lines.

Test Plan:
- MULT 0xFFFFFFFF, 0x00000002 -> after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE. Check busy is high for exactly 5 cycles.
- DIV -7, 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 10 cycles; DIVU 7, 2 -> LO=3, HI=1. Check stall_req is high in the start cycle.
- DIV 5, 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy for 10 cycles; HI/LO remain 0x11/0x22.
- MTHI 0xDEADBEEF then md_sel=1 next cycle -> md_out=0xDEADBEEF with busy=0.
- Start MULT, then assert start DIV while busy -> the second op is ignored, the MULT result commits, and busy falls after 5 cycles.
- Start DIV, assert reset=0 at the 4th busy cycle -> next cycle busy=0, HI=LO=0; release reset; the counter stays 0 and no late commit occurs.
